// File: rtl/usb_tx_framer.sv
// Full-speed USB transmit framer: word FIFO, SYNC, LSB-first bit stuffing,
// NRZI line coding, EOP, and an abort sequence when the FIFO runs dry mid-packet.
module usb_tx_framer #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int STUFF_LEN    = 6,
  parameter int SYNC_BITS    = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              RST,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_last,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              d_plus_out,
  output logic              d_minus_out,
  output logic              tx_1_rx_0,
  output logic              tx_busy,
  output logic              tx_done,
  output logic              tx_err
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int SW    = $clog2(STUFF_LEN + 1);
  localparam int MAXB1 = (DATA_W > SYNC_BITS) ? DATA_W : SYNC_BITS;
  localparam int MAXB  = (MAXB1 > STUFF_LEN + 1) ? MAXB1 : STUFF_LEN + 1;
  localparam int BW    = $clog2(MAXB + 1);

  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_STUFF, S_ABORT, S_EOP} state_t;

  // word FIFO: each entry carries the data word and its packet-last flag
  logic [DATA_W:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count, last_cnt;
  logic              full, empty, push, pop;
  logic [DATA_W-1:0] head_data;
  logic              head_last;

  assign full      = (count == (AW+1)'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign tx_ready  = !full;
  assign push      = tx_valid && !full;
  assign head_data = mem[rd_ptr][DATA_W-1:0];
  assign head_last = mem[rd_ptr][DATA_W];

  // FIFO storage write
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {tx_last, tx_data};
  end

  // FIFO pointers, occupancy and count of queued packet ends
  always_ff @(posedge clk) begin
    if (RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      last_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      unique case ({push && tx_last, pop && head_last})
        2'b10:   last_cnt <= last_cnt + 1'b1;
        2'b01:   last_cnt <= last_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  state_t            state, nxt_state;
  logic [CW-1:0]     clk_cnt;
  logic              strobe;
  logic [BW-1:0]     bit_idx, nxt_bit_idx;
  logic [SW-1:0]     stuff_cnt, nxt_stuff;
  logic [DATA_W-1:0] sh, nxt_sh, src;
  logic              cur_last, nxt_last;
  logic              level, nxt_level, se0, nxt_se0, nxt_oe;
  logic              drop, nxt_drop, eop_pend, nxt_eop_pend;
  logic              err_set, emit, word_end;

  assign strobe   = (clk_cnt == CW'(CLKS_PER_BIT - 1));
  assign word_end = (bit_idx == BW'(DATA_W));
  assign tx_done  = (state == S_EOP) && (bit_idx == BW'(2)) && strobe;

  // bit-time divider, held cleared while idle so the first bit is full length
  always_ff @(posedge clk) begin
    if (RST || state == S_IDLE) clk_cnt <= '0;
    else if (strobe)            clk_cnt <= '0;
    else                        clk_cnt <= clk_cnt + 1'b1;
  end

  // next-state logic: decides the next line bit at each bit strobe
  always_comb begin
    nxt_state    = state;
    nxt_bit_idx  = bit_idx;
    nxt_stuff    = stuff_cnt;
    nxt_sh       = sh;
    nxt_last     = cur_last;
    nxt_eop_pend = eop_pend;
    nxt_level    = level;
    nxt_se0      = se0;
    nxt_oe       = tx_1_rx_0;
    nxt_drop     = drop;
    pop          = 1'b0;
    err_set      = 1'b0;
    emit         = 1'b0;
    src          = sh;
    unique case (state)
      S_IDLE: begin
        nxt_oe    = 1'b0;
        nxt_se0   = 1'b0;
        nxt_level = 1'b1;
        if (drop) begin
          if (!empty) begin
            pop = 1'b1;
            if (head_last) nxt_drop = 1'b0;
          end
        end else if (last_cnt != '0 || full) begin
          nxt_state   = S_SYNC;
          nxt_bit_idx = '0;
          nxt_stuff   = '0;
          nxt_oe      = 1'b1;
          nxt_level   = 1'b0;
        end
      end
      S_SYNC: if (strobe) begin
        if (bit_idx == BW'(SYNC_BITS - 1)) begin
          pop         = 1'b1;
          src         = head_data;
          nxt_last    = head_last;
          nxt_bit_idx = '0;
          nxt_stuff   = SW'(1);
          emit        = 1'b1;
          nxt_state   = S_DATA;
        end else begin
          nxt_bit_idx = bit_idx + 1'b1;
          nxt_level   = (bit_idx == BW'(SYNC_BITS - 2)) ? level : ~level;
        end
      end
      S_DATA: if (strobe) begin
        if (word_end && !cur_last && empty) begin
          nxt_state   = S_ABORT;
          nxt_bit_idx = BW'(1);
          err_set     = 1'b1;
        end else begin
          if (word_end && !cur_last) begin
            pop         = 1'b1;
            src         = head_data;
            nxt_sh      = head_data;
            nxt_last    = head_last;
            nxt_bit_idx = '0;
          end
          if (stuff_cnt == SW'(STUFF_LEN)) begin
            nxt_state    = S_STUFF;
            nxt_level    = ~level;
            nxt_stuff    = '0;
            nxt_eop_pend = word_end && cur_last;
          end else if (word_end && cur_last) begin
            nxt_state   = S_EOP;
            nxt_bit_idx = '0;
            nxt_se0     = 1'b1;
          end else begin
            emit = 1'b1;
          end
        end
      end
      S_STUFF: if (strobe) begin
        if (eop_pend) begin
          nxt_state    = S_EOP;
          nxt_bit_idx  = '0;
          nxt_se0      = 1'b1;
          nxt_eop_pend = 1'b0;
        end else begin
          nxt_state = S_DATA;
          emit      = 1'b1;
        end
      end
      S_ABORT: if (strobe) begin
        if (bit_idx == BW'(STUFF_LEN + 1)) begin
          nxt_state   = S_EOP;
          nxt_bit_idx = '0;
          nxt_se0     = 1'b1;
          nxt_drop    = 1'b1;
        end else begin
          nxt_bit_idx = bit_idx + 1'b1;
        end
      end
      S_EOP: if (strobe) begin
        if (bit_idx == '0) begin
          nxt_bit_idx = BW'(1);
        end else if (bit_idx == BW'(1)) begin
          nxt_bit_idx = BW'(2);
          nxt_se0     = 1'b0;
          nxt_level   = 1'b1;
        end else begin
          nxt_state   = S_IDLE;
          nxt_bit_idx = '0;
          nxt_oe      = 1'b0;
        end
      end
      default: nxt_state = S_IDLE;
    endcase
    if (emit) begin
      nxt_level   = src[0] ? level : ~level;
      nxt_sh      = src >> 1;
      nxt_bit_idx = nxt_bit_idx + 1'b1;
      nxt_stuff   = src[0] ? nxt_stuff + SW'(1) : '0;
    end
  end

  // shift data path, not reset
  always_ff @(posedge clk) begin
    sh       <= nxt_sh;
    cur_last <= nxt_last;
  end

  // control state and registered line outputs
  always_ff @(posedge clk) begin
    if (RST) begin
      state       <= S_IDLE;
      bit_idx     <= '0;
      stuff_cnt   <= '0;
      level       <= 1'b1;
      se0         <= 1'b0;
      drop        <= 1'b0;
      eop_pend    <= 1'b0;
      d_plus_out  <= 1'b0;
      d_minus_out <= 1'b0;
      tx_1_rx_0   <= 1'b0;
      tx_busy     <= 1'b0;
      tx_err      <= 1'b0;
    end else begin
      state       <= nxt_state;
      bit_idx     <= nxt_bit_idx;
      stuff_cnt   <= nxt_stuff;
      level       <= nxt_level;
      se0         <= nxt_se0;
      drop        <= nxt_drop;
      eop_pend    <= nxt_eop_pend;
      d_plus_out  <= nxt_oe && !nxt_se0 && nxt_level;
      d_minus_out <= nxt_oe && !nxt_se0 && !nxt_level;
      tx_1_rx_0   <= nxt_oe;
      tx_busy     <= nxt_oe;
      tx_err      <= err_set;
    end
  end

endmodule
